// File: rtl/pcle_dec_counter.sv
// Loadable, cascadable down-counter with borrow chain, auto-reload and underflow flags.
// Borrow-out is combinational so a chain of stages ripples within one clock.
module pcle_dec_counter #(
   parameter int WIDTH     = 8,
   parameter bit RELOAD_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             cen,
   input  logic             inh,
   input  logic             bin,
   input  logic             auto_rl,
   input  logic             uf_clr,
   output logic [WIDTH-1:0] cnt_q,
   output logic             bout,
   output logic             zero,
   output logic             tc_pulse,
   output logic             uf_stk
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] rl_reg, rl_next;
   logic             tc_reg, stk_reg;
   logic             dec, uf, cnt_is_zero, reload_sel;

   assign cnt_is_zero = (cnt_reg == '0);
   assign dec         = cen & ~inh & bin & ~ld;
   assign uf          = dec & cnt_is_zero;
   assign reload_sel  = RELOAD_EN & auto_rl;

   always_comb begin
      cnt_next = cnt_reg;
      rl_next  = rl_reg;
      if (ld) begin
         cnt_next = ld_val;
         rl_next  = ld_val;
      end else if (dec) begin
         if (!cnt_is_zero)
            cnt_next = cnt_reg - ONE;
         else if (reload_sel)
            cnt_next = rl_reg;
         else
            cnt_next = ALL_ONES;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         rl_reg  <= '0;
         tc_reg  <= 1'b0;
         stk_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         rl_reg  <= rl_next;
         tc_reg  <= uf;
         // a fresh underflow beats a simultaneous clear
         stk_reg <= uf | (stk_reg & ~uf_clr);
      end
   end

   assign cnt_q    = cnt_reg;
   assign bout     = uf;
   assign zero     = cnt_is_zero;
   assign tc_pulse = tc_reg;
   assign uf_stk   = stk_reg;

endmodule
